button_cmd_queue: RTL and testbench
===================================

// Module: button_cmd_queue
// PURPOSE
//  Generalised successor to the board's button command source. Turns N_BUTTONS raw pushbuttons into
//  life-engine commands (codes from command.vh) on a valid/ready interface. Adds auto-repeat and
//  coalescing on the ADVANCE button, plus a sticky drop flag. Sits between board I/O and the engine.
// PARAMETERS
//  N_BUTTONS           4          buttons; idx0 IDLE, 1 ADVANCE, 2 READ_CELL, 3 SEED; idx>=4 ignored
//  SAMPLES_COUNT       5          debounce samples (passed to switch_debouncer)
//  TICKS_PER_SAMPLE    1_000_000  clk ticks per debounce sample
//  REPEAT_DELAY_TICKS  50_000_000 ADVANCE hold time before auto-repeat starts
//  REPEAT_PERIOD_TICKS 10_000_000 ADVANCE auto-repeat period
//  ARG_WIDTH           32         cmd_arg0 width
//  SEED_VALUE          32'hcafebabe  arg sent with CMD_SEED (truncated to ARG_WIDTH)
// PORTS
//  clk        in  1          single clock
//  reset_n    in  1          asynchronous active-low reset
//  buttons    in  N_BUTTONS  raw, asynchronous, active-high
//  cmd        out 3          command code, valid while cmd_valid
//  cmd_arg0   out ARG_WIDTH  command argument
//  cmd_valid  out 1          command pending
//  cmd_ready  in  1          consumer accepts when cmd_valid & cmd_ready
//  dropped    out 1          sticky: a press was discarded
//  clr_dropped in 1          synchronous clear of dropped
// BEHAVIOUR
//  - Reset (async, any cycle, mid-repeat included): cmd_valid=0, cmd=CMD_IDLE, cmd_arg0=0, dropped=0,
//    edge regs=0, repeat FSM=REL, timers=0. Press events fire only on a debounced 0->1 after release.
//  - Event: debounced rising edge (one-cycle, registered), or repeat tick. Same-cycle events:
//    lowest index wins; others dropped (set dropped).
//  - Map: IDLE arg=0; ADVANCE arg=1; READ_CELL arg=0; SEED arg=SEED_VALUE.
//  - Output register, two states:
//    EMPTY: event -> load cmd/arg, cmd_valid=1 next cycle (2 cycles after debounced edge).
//    FULL: cmd/arg stable until handshake. Handshake without event -> EMPTY.
//    Handshake with event -> reload the new command same cycle, stay FULL (no bubble).
//    Event without handshake: ADVANCE on pending ADVANCE -> arg+1, saturating at 2^ARG_WIDTH-1,
//    saturated event sets dropped; any other case -> drop event, set dropped.
//  - Repeat FSM (ADVANCE button only):
//    REL -> DLY on debounced rise (emits press event).
//    DLY: count to REPEAT_DELAY_TICKS -> RPT, emit tick, restart counter.
//    RPT: tick every REPEAT_PERIOD_TICKS.
//    Release in DLY/RPT -> REL, counter cleared.
//  - dropped: set wins over same-cycle clr_dropped. Counters are $clog2 wide and wrap-free.
// STRUCTURE
//  - command.vh (shared header): CMD_* codes, CMD_WIDTH=3. Also BTN_IDLE..BTN_SEED index defines.
//  - Reuse switch_debouncer (WIDTH=N_BUTTONS, reset_n=reset_n).
//  - New sub-module button_repeater: repeat FSM plus timer.
//    Parameters REPEAT_DELAY_TICKS, REPEAT_PERIOD_TICKS; ports clk, reset_n, level_in, tick_out.
//  - Edge detect, priority select and the output register stay in this module.
// TESTING  (TICKS_PER_SAMPLE=2, SAMPLES_COUNT=3, REPEAT_DELAY=20, REPEAT_PERIOD=8, ARG_WIDTH=4)
//  1. Press btn3, ready=1 -> one beat: cmd=CMD_SEED, arg=4'he. Valid 2 clk after debounced rise, 1 cycle.
//  2. Hold btn1 for 60 clk, ready=1 -> ADVANCE arg=1 at press, then 20 clk later, then every 8 clk;
//     release -> no further beats.
//  3. ready=0, press btn1 five times -> single pending ADVANCE arg=5, dropped=0.
//     Then 12 more presses -> arg saturates at 15, dropped=1.
//  4. ready=0, pending IDLE; press btn2 -> arg/cmd unchanged, dropped=1.
//     clr_dropped -> 0. Same-cycle set+clr -> stays 1.
//  5. btn0 and btn2 debounced-rise same cycle -> CMD_IDLE emitted, dropped=1.
//     Handshake plus new event same cycle -> back-to-back valid, no gap.
//  6. Assert reset_n=0 mid-RPT with valid=1 -> outputs reset immediately (async).
//     Button still held after reset -> no command until released and pressed again.

Source files
------------

// File: rtl/button_cmd_queue_pkg.sv
// Shared definitions for the button command queue: command codes, button indices,
// FSM state types and a counter-width helper.
package button_cmd_queue_pkg;

  localparam int unsigned CMD_WIDTH     = 3;
  localparam int unsigned EV_W          = 4;
  localparam int unsigned IDX_W         = 2;

  localparam int unsigned BTN_IDLE      = 0;
  localparam int unsigned BTN_ADVANCE   = 1;
  localparam int unsigned BTN_READ_CELL = 2;
  localparam int unsigned BTN_SEED      = 3;

  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_IDLE      = 3'd0,
    CMD_ADVANCE   = 3'd1,
    CMD_READ_CELL = 3'd2,
    CMD_SEED      = 3'd3
  } cmd_e;

  typedef enum logic {
    Q_EMPTY = 1'b0,
    Q_FULL  = 1'b1
  } q_state_e;

  typedef enum logic [1:0] {
    RPT_REL = 2'd0,
    RPT_DLY = 2'd1,
    RPT_RPT = 2'd2
  } rpt_state_e;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_repeater.sv
// Auto-repeat for a held level: one tick after REPEAT_DELAY_TICKS, then one every
// REPEAT_PERIOD_TICKS until the level drops.
module button_repeater
  import button_cmd_queue_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY_TICKS  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD_TICKS = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level_in,
  output logic tick_out
);

  localparam int unsigned MAX_TICKS = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                                      REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int unsigned CNT_W = cnt_width(MAX_TICKS);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_TICKS - 1);

  rpt_state_e       r_state;
  rpt_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;
  logic             w_tick_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RPT_REL;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    unique case (r_state)
      RPT_REL: begin
        if (level_in) begin
          w_state_nxt = RPT_DLY;
          w_cnt_nxt   = '0;
        end
      end
      RPT_DLY: begin
        if (!level_in) begin
          w_state_nxt = RPT_REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DLY_LAST) begin
          w_state_nxt = RPT_RPT;
          w_cnt_nxt   = '0;
          w_tick_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RPT_RPT: begin
        if (!level_in) begin
          w_state_nxt = RPT_REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PER_LAST) begin
          w_cnt_nxt  = '0;
          w_tick_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RPT_REL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign tick_out = r_tick;

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises raw switches and only changes a debounced level after SAMPLES_COUNT
// consecutive disagreeing samples taken every TICKS_PER_SAMPLE clocks.
module switch_debouncer
  import button_cmd_queue_pkg::*;
#(
  parameter int unsigned WIDTH            = 4,
  parameter int unsigned SAMPLES_COUNT    = 5,
  parameter int unsigned TICKS_PER_SAMPLE = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw_db
);

  localparam int unsigned TICK_W = cnt_width(TICKS_PER_SAMPLE);
  localparam int unsigned SAMP_W = cnt_width(SAMPLES_COUNT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLES_COUNT - 1);

  logic [WIDTH-1:0]             r_sync1;
  logic [WIDTH-1:0]             r_sync2;
  logic [WIDTH-1:0]             r_level;
  logic [TICK_W-1:0]            r_tick_cnt;
  logic [WIDTH-1:0][SAMP_W-1:0] r_run;
  logic                         w_sample;

  assign w_sample = (r_tick_cnt == TICK_LAST);

  // Level resets high (treated as pressed) so a button held through reset is
  // never mistaken for a fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_level    <= '1;
      r_tick_cnt <= '0;
      r_run      <= '0;
    end else begin
      r_sync1    <= i_sw;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_sample ? '0 : r_tick_cnt + TICK_W'(1);
      if (w_sample) begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (r_sync2[i] == r_level[i]) begin
            r_run[i] <= '0;
          end else if (r_run[i] == SAMP_LAST) begin
            r_level[i] <= ~r_level[i];
            r_run[i]   <= '0;
          end else begin
            r_run[i] <= r_run[i] + SAMP_W'(1);
          end
        end
      end
    end
  end

  assign o_sw_db = r_level;

endmodule

// File: rtl/button_cmd_queue.sv
// Pushbuttons to life-engine commands on a valid/ready port, with ADVANCE auto-repeat,
// ADVANCE coalescing into a pending command, and a sticky dropped flag.
module button_cmd_queue
  import button_cmd_queue_pkg::*;
#(
  parameter int unsigned N_BUTTONS           = 4,
  parameter int unsigned SAMPLES_COUNT       = 5,
  parameter int unsigned TICKS_PER_SAMPLE    = 1_000_000,
  parameter int unsigned REPEAT_DELAY_TICKS  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD_TICKS = 10_000_000,
  parameter int unsigned ARG_WIDTH           = 32,
  parameter logic [31:0] SEED_VALUE          = 32'hcafebabe
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [CMD_WIDTH-1:0] cmd,
  output logic [ARG_WIDTH-1:0] cmd_arg0,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 dropped,
  input  logic                 clr_dropped
);

  localparam int unsigned N_USED = (N_BUTTONS < EV_W) ? N_BUTTONS : EV_W;
  localparam logic [ARG_WIDTH-1:0] SEED_ARG = ARG_WIDTH'(SEED_VALUE);
  localparam logic [ARG_WIDTH-1:0] ARG_MAX  = '1;

  logic [N_BUTTONS-1:0] w_db;
  logic [N_USED-1:0]    r_db_prev;
  logic [N_USED-1:0]    r_armed;
  logic [N_USED-1:0]    r_rise;
  logic                 w_rpt_level;
  logic                 w_tick;

  logic [EV_W-1:0]      w_ev;
  logic                 w_ev_valid;
  logic                 w_ev_multi;
  logic [IDX_W-1:0]     w_ev_idx;
  cmd_e                 w_ev_cmd;
  logic [ARG_WIDTH-1:0] w_ev_arg;

  q_state_e             r_state;
  q_state_e             w_state_nxt;
  cmd_e                 r_cmd;
  cmd_e                 w_cmd_nxt;
  logic [ARG_WIDTH-1:0] r_arg;
  logic [ARG_WIDTH-1:0] w_arg_nxt;
  logic                 r_dropped;
  logic                 w_drop_set;

  switch_debouncer #(
    .WIDTH            (N_BUTTONS),
    .SAMPLES_COUNT    (SAMPLES_COUNT),
    .TICKS_PER_SAMPLE (TICKS_PER_SAMPLE)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .i_sw    (buttons),
    .o_sw_db (w_db)
  );

  assign w_rpt_level = w_db[BTN_ADVANCE] & r_armed[BTN_ADVANCE];

  button_repeater #(
    .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
    .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS)
  ) u_repeat (
    .clk      (clk),
    .reset_n  (reset_n),
    .level_in (w_rpt_level),
    .tick_out (w_tick)
  );

  // A button arms only after a debounced release, so only a real 0->1 fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_prev <= '0;
      r_armed   <= '0;
      r_rise    <= '0;
    end else begin
      r_armed   <= r_armed | ~w_db[N_USED-1:0];
      r_db_prev <= w_db[N_USED-1:0];
      r_rise    <= w_db[N_USED-1:0] & ~r_db_prev & r_armed;
    end
  end

  // Event vector, lowest-index priority and command mapping.
  always_comb begin
    w_ev                = '0;
    w_ev[N_USED-1:0]    = r_rise;
    w_ev[BTN_ADVANCE]   = w_ev[BTN_ADVANCE] | w_tick;
    w_ev_valid          = |w_ev;
    w_ev_multi          = |(w_ev & (w_ev - EV_W'(1)));
    w_ev_idx            = '0;
    for (int i = int'(EV_W) - 1; i >= 0; i--) begin
      if (w_ev[i]) w_ev_idx = IDX_W'(i);
    end
    w_ev_cmd = CMD_IDLE;
    w_ev_arg = '0;
    case (w_ev_idx)
      IDX_W'(BTN_ADVANCE):   begin w_ev_cmd = CMD_ADVANCE;   w_ev_arg = ARG_WIDTH'(1); end
      IDX_W'(BTN_READ_CELL): begin w_ev_cmd = CMD_READ_CELL; w_ev_arg = '0;            end
      IDX_W'(BTN_SEED):      begin w_ev_cmd = CMD_SEED;      w_ev_arg = SEED_ARG;      end
      default:               begin w_ev_cmd = CMD_IDLE;      w_ev_arg = '0;            end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= Q_EMPTY;
      r_cmd     <= CMD_IDLE;
      r_arg     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_arg   <= w_arg_nxt;
      if (w_drop_set) begin
        r_dropped <= 1'b1;
      end else if (clr_dropped) begin
        r_dropped <= 1'b0;
      end
    end
  end

  // Output slot: handshake with a new event reloads without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_arg_nxt   = r_arg;
    w_drop_set  = w_ev_multi;
    unique case (r_state)
      Q_EMPTY: begin
        if (w_ev_valid) begin
          w_state_nxt = Q_FULL;
          w_cmd_nxt   = w_ev_cmd;
          w_arg_nxt   = w_ev_arg;
        end
      end
      Q_FULL: begin
        if (cmd_ready) begin
          if (w_ev_valid) begin
            w_cmd_nxt = w_ev_cmd;
            w_arg_nxt = w_ev_arg;
          end else begin
            w_state_nxt = Q_EMPTY;
          end
        end else if (w_ev_valid) begin
          if ((w_ev_cmd == CMD_ADVANCE) && (r_cmd == CMD_ADVANCE)) begin
            if (r_arg == ARG_MAX) begin
              w_drop_set = 1'b1;
            end else begin
              w_arg_nxt = r_arg + ARG_WIDTH'(1);
            end
          end else begin
            w_drop_set = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = Q_EMPTY;
      end
    endcase
  end

  assign cmd       = r_cmd;
  assign cmd_arg0  = r_arg;
  assign cmd_valid = (r_state == Q_FULL);
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_button_cmd_queue.sv
// Scoreboard bench for button_cmd_queue with short debounce/repeat timing.
module tb_button_cmd_queue;
  import button_cmd_queue_pkg::*;

  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [CMD_WIDTH-1:0] c;
    logic [AW-1:0]        a;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [3:0]           buttons = '0;
  logic [CMD_WIDTH-1:0] cmd;
  logic [AW-1:0]        cmd_arg0;
  logic                 cmd_valid;
  logic                 cmd_ready = 1'b0;
  logic                 dropped;
  logic                 clr_dropped = 1'b0;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    rise_cyc = -1;
  logic  prev_db3 = 1'b0;
  beat_t exp_q[$];
  int    beat_cyc[$];

  always #5 clk = ~clk;

  button_cmd_queue #(
    .N_BUTTONS           (4),
    .SAMPLES_COUNT       (3),
    .TICKS_PER_SAMPLE    (2),
    .REPEAT_DELAY_TICKS  (20),
    .REPEAT_PERIOD_TICKS (8),
    .ARG_WIDTH           (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .buttons     (buttons),
    .cmd         (cmd),
    .cmd_arg0    (cmd_arg0),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .dropped     (dropped),
    .clr_dropped (clr_dropped)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input cmd_e c, input logic [AW-1:0] a);
    beat_t b;
    b.c = c;
    b.a = a;
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples mid-low-phase, after any negedge-driven inputs settle.
  always @(negedge clk) begin
    beat_t e;
    #2;
    if (reset_n) begin
      if (dut.w_db[3] && !prev_db3) rise_cyc = cyc;
      prev_db3 = dut.w_db[3];
      if (cmd_valid && cmd_ready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 32'(cmd), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_cmd", 32'(cmd), 32'(e.c));
          check_eq("beat_arg", 32'(cmd_arg0), 32'(e.a));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    buttons = buttons | m;
    tick(hold);
    buttons = buttons & ~m;
    tick(14);
  endtask

  task automatic clr_pulse();
    clr_dropped = 1'b1;
    tick(1);
    clr_dropped = 1'b0;
  endtask

  task automatic wait_ev(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.w_ev_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n0;
    bit ok;
    int gaps[5] = '{20, 8, 8, 8, 8};

    // Reset values
    tick(3);
    check_eq("rst_valid", 32'(cmd_valid), 0);
    check_eq("rst_cmd", 32'(cmd), 32'(CMD_IDLE));
    check_eq("rst_arg", 32'(cmd_arg0), 0);
    check_eq("rst_dropped", 32'(dropped), 0);
    reset_n = 1'b1;
    tick(30);

    // 1: SEED single beat, valid two cycles after the debounced rise
    cmd_ready = 1'b1;
    n0 = beat_cyc.size();
    exp_q.push_back(mk(CMD_SEED, 4'he));
    press(4'b1000, 12);
    tick(10);
    check_eq("t1_beats", 32'(beat_cyc.size() - n0), 1);
    if (beat_cyc.size() > n0) check_eq("t1_latency", 32'(beat_cyc[n0] - rise_cyc), 2);

    // 2: hold ADVANCE for 60 clocks: press beat then +20, then every 8
    n0 = beat_cyc.size();
    repeat (6) exp_q.push_back(mk(CMD_ADVANCE, 4'd1));
    buttons[1] = 1'b1;
    tick(60);
    buttons[1] = 1'b0;
    tick(40);
    check_eq("t2_beats", 32'(beat_cyc.size() - n0), 6);
    if (beat_cyc.size() >= n0 + 6)
      for (int i = 0; i < 5; i++)
        check_eq($sformatf("t2_gap%0d", i), 32'(beat_cyc[n0+i+1] - beat_cyc[n0+i]), 32'(gaps[i]));
    check_eq("t2_q_empty", 32'(exp_q.size()), 0);

    // 3: coalescing while stalled, then saturation
    cmd_ready = 1'b0;
    repeat (5) press(4'b0010, 12);
    check_eq("t3_valid", 32'(cmd_valid), 1);
    check_eq("t3_cmd", 32'(cmd), 32'(CMD_ADVANCE));
    check_eq("t3_arg5", 32'(cmd_arg0), 5);
    check_eq("t3_drop0", 32'(dropped), 0);
    repeat (12) press(4'b0010, 12);
    check_eq("t3_arg_sat", 32'(cmd_arg0), 15);
    check_eq("t3_drop1", 32'(dropped), 1);
    exp_q.push_back(mk(CMD_ADVANCE, 4'd15));
    cmd_ready = 1'b1;
    tick(3);
    check_eq("t3_drained", 32'(exp_q.size()), 0);
    clr_pulse();
    check_eq("t3_clr", 32'(dropped), 0);

    // 4: non-ADVANCE event on pending command is dropped
    cmd_ready = 1'b0;
    press(4'b0001, 12);
    check_eq("t4_pend_valid", 32'(cmd_valid), 1);
    check_eq("t4_drop0", 32'(dropped), 0);
    press(4'b0100, 12);
    check_eq("t4_cmd_kept", 32'(cmd), 32'(CMD_IDLE));
    check_eq("t4_arg_kept", 32'(cmd_arg0), 0);
    check_eq("t4_drop1", 32'(dropped), 1);
    clr_pulse();
    check_eq("t4_clr", 32'(dropped), 0);
    buttons[2] = 1'b1;
    wait_ev(ok);
    check_eq("t4_ev_seen", 32'(ok), 1);
    clr_dropped = 1'b1;
    @(negedge clk);
    clr_dropped = 1'b0;
    #1;
    check_eq("t4_set_wins", 32'(dropped), 1);
    tick(1);
    buttons[2] = 1'b0;
    tick(14);
    clr_pulse();
    exp_q.push_back(mk(CMD_IDLE, 4'd0));
    cmd_ready = 1'b1;
    tick(3);
    check_eq("t4_drained", 32'(exp_q.size()), 0);

    // 5: simultaneous IDLE+READ_CELL, then back-to-back reload
    exp_q.push_back(mk(CMD_IDLE, 4'd0));
    press(4'b0101, 12);
    check_eq("t5_drop", 32'(dropped), 1);
    clr_pulse();
    cmd_ready = 1'b0;
    press(4'b1000, 12);
    exp_q.push_back(mk(CMD_SEED, 4'he));
    exp_q.push_back(mk(CMD_ADVANCE, 4'd1));
    n0 = beat_cyc.size();
    buttons[1] = 1'b1;
    wait_ev(ok);
    check_eq("t5_ev_seen", 32'(ok), 1);
    cmd_ready = 1'b1;
    tick(1);
    check_eq("t5_reload_valid", 32'(cmd_valid), 1);
    check_eq("t5_reload_cmd", 32'(cmd), 32'(CMD_ADVANCE));
    buttons[1] = 1'b0;
    tick(14);
    check_eq("t5_beats", 32'(beat_cyc.size() - n0), 2);
    if (beat_cyc.size() >= n0 + 2) check_eq("t5_no_gap", 32'(beat_cyc[n0+1] - beat_cyc[n0]), 1);
    check_eq("t5_drop_clean", 32'(dropped), 0);

    // 6: async reset mid-repeat; held button must not fire after reset
    cmd_ready = 1'b0;
    buttons[1] = 1'b1;
    tick(45);
    check_eq("t6_pre_valid", 32'(cmd_valid), 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(cmd_valid), 0);
    check_eq("t6_rst_cmd", 32'(cmd), 32'(CMD_IDLE));
    check_eq("t6_rst_arg", 32'(cmd_arg0), 0);
    check_eq("t6_rst_drop", 32'(dropped), 0);
    tick(2);
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    n0 = beat_cyc.size();
    tick(60);
    check_eq("t6_held_no_beat", 32'(beat_cyc.size() - n0), 0);
    check_eq("t6_held_valid", 32'(cmd_valid), 0);
    buttons[1] = 1'b0;
    tick(20);
    exp_q.push_back(mk(CMD_ADVANCE, 4'd1));
    press(4'b0010, 12);
    tick(5);
    check_eq("t6_repress_beat", 32'(beat_cyc.size() - n0), 1);
    check_eq("final_q_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
